shared_res_arbiter: RTL and testbench

SHARED_RES_ARBITER -- requirements
Module: shared_res_arbiter

---
 rtl/shared_res_arbiter.sv | 115 +++++++++++
 tb/tb_shared_res_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/shared_res_arbiter.sv
// Round-robin arbiter in front of a shared fixed-latency incrementer.
// The winning operand is executed for LAT cycles, then returned through a valid/ready response.
module shared_res_arbiter #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int LAT = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic           rsp_valid,
  output logic [W-1:0]   rsp_data,
  output logic [IW-1:0]  rsp_id,
  input  logic           rsp_ready
);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;

  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [IW-1:0] win_sel;
  logic [IW-1:0] cand;
  logic          found;
  logic          grant;
  logic          exec_done;
  logic          hshk;
  int            idx;
  logic [W-1:0]  data_arr [N];
  logic [W-1:0]  op_p0;
  logic [IW-1:0] win_p0;

  function automatic logic [W-1:0] inc_wrap(input logic [W-1:0] x);
    return x + W'(1);
  endfunction

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (int'(i) == N - 1) ? '0 : i + IW'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) data_arr[i] = req_data[i*W +: W];
  end

  // Search upward from ptr, wrapping N-1 -> 0; first set request wins
  always_comb begin
    found   = 1'b0;
    win_sel = '0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      cand = IW'(idx);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_sel = cand;
      end
    end
  end

  assign grant     = (state == IDLE) && !rst && found;
  assign exec_done = (state == EXEC) && (cnt == '0);
  assign hshk      = (state == RESP) && rsp_ready;
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_nxt = state;
    gnt       = '0;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt    = EXEC;
          gnt[win_sel] = 1'b1;
        end
      end
      EXEC:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) cnt <= CW'(LAT - 1);
      else if ((state == EXEC) && (cnt != '0)) cnt <= cnt - CW'(1);
      if (hshk) ptr <= next_idx(win_p0);
      if (exec_done) begin
        rsp_data <= inc_wrap(op_p0);
        rsp_id   <= win_p0;
      end
    end
  end

  // Stage p0: operand and owner captured at the grant edge
  always_ff @(posedge clk) begin
    if (grant) begin
      op_p0  <= data_arr[win_sel];
      win_p0 <= win_sel;
    end
  end
endmodule

// File: tb/tb_shared_res_arbiter.sv
// Bench for shared_res_arbiter: directed vector table, rotation sequence,
// and randomized traffic checked against a transaction-level model.
module tb_shared_res_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 2;
  localparam int IW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [IW-1:0]  rsp_id;
  logic           rsp_ready;

  always #5 clk = ~clk;

  shared_res_arbiter #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic        rdy;
    logic [3:0]  e_gnt;
    logic        e_busy;
    logic        e_vld;
    logic [7:0]  e_data;
    logic [1:0]  e_id;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] q, input logic [31:0] d, input logic y,
                     input logic [3:0] g, input logic b, input logic v, input logic [7:0] rd,
                     input logic [1:0] ri);
    vec_t e;
    e.rst = r; e.req = q; e.data = d; e.rdy = y;
    e.e_gnt = g; e.e_busy = b; e.e_vld = v; e.e_data = rd; e.e_id = ri;
    tbl.push_back(e);
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  int m_active, m_ptr, m_win, m_resp_at, cyc, p, ng;
  logic [W-1:0] m_res;
  logic [N-1:0] e_gnt;
  logic e_busy, e_vld;
  int g_id[$];
  int g_cyc[$];

  initial begin
    rst = 1'b1; req = '0; req_data = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // rst, req, data, rdy | gnt, busy, vld, rsp_data, rsp_id
    add(1, 4'b0000, 32'h0,        0, 4'b0000, 0, 0, 8'h00, 2'd0);
    add(0, 4'b0100, 32'h003C0000, 1, 4'b0100, 0, 0, 8'h00, 2'd0);
    add(0, 4'b0000, 32'h0,        1, 4'b0000, 1, 0, 8'h00, 2'd0);
    add(0, 4'b0000, 32'h0,        1, 4'b0000, 1, 0, 8'h00, 2'd0);
    add(0, 4'b0000, 32'h0,        1, 4'b0000, 1, 1, 8'h3D, 2'd2);
    add(0, 4'b1000, 32'h10000000, 1, 4'b1000, 0, 0, 8'h3D, 2'd2);
    add(0, 4'b0000, 32'h0,        1, 4'b0000, 1, 0, 8'h3D, 2'd2);
    add(0, 4'b0000, 32'h0,        1, 4'b0000, 1, 0, 8'h3D, 2'd2);
    add(0, 4'b0000, 32'h0,        1, 4'b0000, 1, 1, 8'h11, 2'd3);
    add(0, 4'b1001, 32'h000000FF, 1, 4'b0001, 0, 0, 8'h11, 2'd3);
    add(0, 4'b0000, 32'h0,        1, 4'b0000, 1, 0, 8'h11, 2'd3);
    add(0, 4'b0000, 32'h0,        1, 4'b0000, 1, 0, 8'h11, 2'd3);
    for (int i = 0; i < 5; i++)
      add(0, 4'b0010, 32'h00005500, 0, 4'b0000, 1, 1, 8'h00, 2'd0);
    add(0, 4'b0010, 32'h00005500, 1, 4'b0000, 1, 1, 8'h00, 2'd0);
    add(0, 4'b0010, 32'h00005500, 1, 4'b0010, 0, 0, 8'h00, 2'd0);
    add(0, 4'b0000, 32'h0,        1, 4'b0000, 1, 0, 8'h00, 2'd0);
    add(1, 4'b0000, 32'h0,        1, 4'b0000, 1, 0, 8'h00, 2'd0);
    add(0, 4'b1010, 32'h7F002000, 1, 4'b0010, 0, 0, 8'h00, 2'd0);
    add(0, 4'b0000, 32'h0,        1, 4'b0000, 1, 0, 8'h00, 2'd0);
    add(0, 4'b0000, 32'h0,        1, 4'b0000, 1, 0, 8'h00, 2'd0);
    add(0, 4'b0001, 32'h0,        1, 4'b0000, 1, 1, 8'h21, 2'd1);
    add(0, 4'b0000, 32'h0,        1, 4'b0000, 0, 0, 8'h21, 2'd1);
    add(0, 4'b0000, 32'h0,        1, 4'b0000, 0, 0, 8'h21, 2'd1);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; req = tbl[i].req; req_data = tbl[i].data; rsp_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i),  gnt,       tbl[i].e_gnt);
      chk($sformatf("tbl%0d_busy", i), busy,      tbl[i].e_busy);
      chk($sformatf("tbl%0d_vld", i),  rsp_valid, tbl[i].e_vld);
      chk($sformatf("tbl%0d_data", i), rsp_data,  tbl[i].e_data);
      chk($sformatf("tbl%0d_id", i),   rsp_id,    tbl[i].e_id);
      @(posedge clk);
      #1;
    end

    // All requesters held: strict rotation, one grant every LAT+2 cycles
    rst = 1'b1; req = '0; rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; req = 4'b1111; req_data = 32'h40302010;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      if (gnt != '0) begin
        for (int b = 0; b < N; b++) if (gnt[b]) g_id.push_back(b);
        g_cyc.push_back(c);
        chk("rot_onehot", $countones(gnt), 1);
      end
      @(posedge clk);
      #1;
    end
    ng = g_id.size();
    chk("rot_count", ng, 5);
    for (int k = 0; k < 5 && k < ng; k++) begin
      chk($sformatf("rot_id%0d", k), g_id[k], k % N);
      if (k > 0) chk($sformatf("rot_gap%0d", k), g_cyc[k] - g_cyc[k-1], LAT + 2);
    end

    // Randomized traffic against the transaction model
    rst = 1'b1; req = '0;
    @(posedge clk);
    #1;
    m_active = 0; m_ptr = 0; m_win = 0; m_resp_at = 0; m_res = '0; cyc = 0;
    for (int t = 0; t < 3000; t++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req       = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      req_data  = $urandom;
      rsp_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      p = pick(req, m_ptr);
      if (m_active == 0) begin
        e_busy = 1'b0; e_vld = 1'b0;
        e_gnt  = (rst || p < 0) ? '0 : N'(1) << p;
      end else begin
        e_busy = 1'b1; e_vld = (cyc >= m_resp_at); e_gnt = '0;
      end
      chk("rnd_gnt",  gnt,       e_gnt);
      chk("rnd_busy", busy,      e_busy);
      chk("rnd_vld",  rsp_valid, e_vld);
      if (e_vld) begin
        chk("rnd_data", rsp_data, m_res);
        chk("rnd_id",   rsp_id,   m_win);
      end
      @(posedge clk);
      if (rst) begin
        m_active = 0; m_ptr = 0;
      end else if (m_active == 0) begin
        if (p >= 0) begin
          m_active  = 1;
          m_win     = p;
          m_res     = W'((int'(req_data[p*W +: W]) + 1) % (1 << W));
          m_resp_at = cyc + LAT + 1;
        end
      end else if (cyc >= m_resp_at && rsp_ready) begin
        m_active = 0;
        m_ptr    = (m_win + 1) % N;
      end
      cyc++;
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
